// File: rtl/trap_controller_pkg.sv
// trap_controller_pkg
//   Shared constants for the machine-mode CSR / trap unit: CSR addresses,
//   CSR operation encodings, interrupt cause codes, synchronous exception
//   codes, and a helper that builds the set of implemented interrupt bits.
package trap_controller_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  localparam logic [1:0] CSR_OP_RSV = 2'b00;
  localparam logic [1:0] CSR_OP_RW  = 2'b01;
  localparam logic [1:0] CSR_OP_RS  = 2'b10;
  localparam logic [1:0] CSR_OP_RC  = 2'b11;

  localparam int CAUSE_MTI        = 7;
  localparam int CAUSE_MEI        = 11;
  localparam int CAUSE_LOCAL_BASE = 16;

  typedef enum logic [3:0] {
    EXC_INSN_MISALIGNED  = 4'd0,
    EXC_INSN_ACCESS      = 4'd1,
    EXC_ILLEGAL_INSN     = 4'd2,
    EXC_BREAKPOINT       = 4'd3,
    EXC_LOAD_MISALIGNED  = 4'd4,
    EXC_LOAD_ACCESS      = 4'd5,
    EXC_STORE_MISALIGNED = 4'd6,
    EXC_STORE_ACCESS     = 4'd7,
    EXC_ECALL_U          = 4'd8,
    EXC_ECALL_S          = 4'd9,
    EXC_RESERVED_10      = 4'd10,
    EXC_ECALL_M          = 4'd11
  } exc_code_e;

  // Interrupt bits that exist in mip/mie: MTI, MEI and the local lines.
  function automatic logic [31:0] irq_bit_mask(input int unsigned num_local);
    logic [31:0] m;
    m = 32'h0000_0880;
    for (int k = 0; k < 16; k++) begin
      if (k < int'(num_local)) m[CAUSE_LOCAL_BASE + k] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/trap_controller_if.sv
// trap_controller_if
//   Commit-stage connection between the core (master) and the trap unit
//   (slave): CSR access, interrupt levels, trap/mret requests and the
//   returned PC redirect.
interface trap_controller_if #(
  parameter int unsigned NUM_LOCAL_IRQ = 4
);
  logic                     csr_valid_i;
  logic [11:0]              csr_addr_i;
  logic [1:0]               csr_op_i;
  logic [31:0]              csr_wdata_i;
  logic [31:0]              csr_rdata_o;
  logic                     csr_illegal_o;
  logic                     timer_irq_i;
  logic                     external_irq_i;
  logic [NUM_LOCAL_IRQ-1:0] local_irq_i;
  logic                     boundary_i;
  logic [31:0]              pc_i;
  logic                     exc_valid_i;
  logic [3:0]               exc_cause_i;
  logic [31:0]              exc_tval_i;
  logic                     mret_i;
  logic                     redirect_o;
  logic [31:0]              redirect_pc_o;
  logic                     irq_pending_o;

  modport master (
    output csr_valid_i, csr_addr_i, csr_op_i, csr_wdata_i,
    output timer_irq_i, external_irq_i, local_irq_i,
    output boundary_i, pc_i, exc_valid_i, exc_cause_i, exc_tval_i, mret_i,
    input  csr_rdata_o, csr_illegal_o, redirect_o, redirect_pc_o, irq_pending_o
  );

  modport slave (
    input  csr_valid_i, csr_addr_i, csr_op_i, csr_wdata_i,
    input  timer_irq_i, external_irq_i, local_irq_i,
    input  boundary_i, pc_i, exc_valid_i, exc_cause_i, exc_tval_i, mret_i,
    output csr_rdata_o, csr_illegal_o, redirect_o, redirect_pc_o, irq_pending_o
  );
endinterface

// File: rtl/trap_controller_irq_priority_encoder.sv
// trap_controller_irq_priority_encoder
//   Fixed-priority selection over the masked pending vector.
//   Order: MEI (11) > MTI (7) > local lines, lowest local index first.
//   Ports: pend (masked pending vector), valid (any source set),
//          code (cause code of the winner).
module trap_controller_irq_priority_encoder
  import trap_controller_pkg::*;
#(
  parameter int unsigned NUM_LOCAL_IRQ = 4
) (
  input  logic [31:0] pend,
  output logic        valid,
  output logic [4:0]  code
);

  localparam logic [31:0] SRC_MASK = irq_bit_mask(NUM_LOCAL_IRQ);

  // Bits outside the implemented sources are always zero upstream.
  logic unused_pend;
  assign unused_pend = |(pend & ~SRC_MASK);

  // Later assignments win, so scan from lowest to highest priority.
  always_comb begin
    valid = 1'b0;
    code  = '0;
    for (int k = int'(NUM_LOCAL_IRQ) - 1; k >= 0; k--) begin
      if (pend[CAUSE_LOCAL_BASE + k]) begin
        valid = 1'b1;
        code  = 5'(CAUSE_LOCAL_BASE + k);
      end
    end
    if (pend[CAUSE_MTI]) begin
      valid = 1'b1;
      code  = 5'(CAUSE_MTI);
    end
    if (pend[CAUSE_MEI]) begin
      valid = 1'b1;
      code  = 5'(CAUSE_MEI);
    end
  end

endmodule

// File: rtl/trap_controller.sv
// trap_controller
//   Machine-mode CSR file and trap unit for the multi-cycle RV32I core.
//   Handles CSR read/modify/write, synchronous exceptions, interrupts
//   (timer, external, NUM_LOCAL_IRQ local lines), mret, and direct or
//   vectored mtvec redirection.
//   Ports: clk_i, rst_i (synchronous, active high);
//          bus (trap_controller_if.slave): CSR access, interrupt levels,
//          commit-point trap/mret requests, redirect outputs.
module trap_controller
  import trap_controller_pkg::*;
#(
  parameter int unsigned NUM_LOCAL_IRQ = 4,
  parameter logic [31:0] TRAP_PC       = 32'h0000_0000,
  parameter bit          VECTORED      = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  trap_controller_if.slave bus
);

  localparam logic [31:0] MIE_MASK   = irq_bit_mask(NUM_LOCAL_IRQ);
  localparam logic [31:0] MTVEC_MASK = VECTORED ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;
  localparam logic [31:0] MEPC_MASK  = 32'hFFFF_FFFC;

  logic        mstatus_mie_q;
  logic        mstatus_mpie_q;
  logic [31:0] mie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;

  logic [31:0] mip_w;
  logic [31:0] pend;
  logic        irq_valid;
  logic [4:0]  irq_code;
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic        addr_ok;
  logic        op_ok;
  logic        trap;
  logic        take_mret;
  logic        csr_we;
  logic        illegal;
  logic [31:0] trap_cause;
  logic [31:0] trap_target;

  always_comb begin
    mip_w                               = '0;
    mip_w[CAUSE_MTI]                    = bus.timer_irq_i;
    mip_w[CAUSE_MEI]                    = bus.external_irq_i;
    mip_w[CAUSE_LOCAL_BASE +: NUM_LOCAL_IRQ] = bus.local_irq_i;
  end

  assign pend = mip_w & mie_q & {32{mstatus_mie_q}};

  trap_controller_irq_priority_encoder #(
    .NUM_LOCAL_IRQ (NUM_LOCAL_IRQ)
  ) u_prio (
    .pend  (pend),
    .valid (irq_valid),
    .code  (irq_code)
  );

  always_comb begin
    old_val = '0;
    addr_ok = 1'b1;
    case (bus.csr_addr_i)
      CSR_MSTATUS:  old_val = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
      CSR_MIE:      old_val = mie_q;
      CSR_MTVEC:    old_val = mtvec_q;
      CSR_MSCRATCH: old_val = mscratch_q;
      CSR_MEPC:     old_val = mepc_q;
      CSR_MCAUSE:   old_val = mcause_q;
      CSR_MTVAL:    old_val = mtval_q;
      CSR_MIP:      old_val = mip_w;
      default:      addr_ok = 1'b0;
    endcase
  end

  always_comb begin
    case (bus.csr_op_i)
      CSR_OP_RW: new_val = bus.csr_wdata_i;
      CSR_OP_RS: new_val = old_val | bus.csr_wdata_i;
      CSR_OP_RC: new_val = old_val & ~bus.csr_wdata_i;
      default:   new_val = old_val;
    endcase
  end

  assign op_ok     = (bus.csr_op_i != CSR_OP_RSV);
  assign trap      = !rst_i && bus.boundary_i && (bus.exc_valid_i || irq_valid);
  assign take_mret = !rst_i && bus.boundary_i && bus.mret_i && !trap;
  assign illegal   = !rst_i && bus.csr_valid_i && !trap && !(addr_ok && op_ok);
  assign csr_we    = !rst_i && bus.csr_valid_i && !trap && addr_ok && op_ok;

  // Exceptions win over interrupts; only interrupts use the vector offset.
  always_comb begin
    if (bus.exc_valid_i) begin
      trap_cause  = {28'b0, bus.exc_cause_i};
      trap_target = {mtvec_q[31:2], 2'b00};
    end else begin
      trap_cause  = {1'b1, 26'b0, irq_code};
      trap_target = {mtvec_q[31:2], 2'b00};
      if (mtvec_q[0]) trap_target = trap_target + {25'b0, irq_code, 2'b00};
    end
  end

  assign bus.csr_rdata_o   = (rst_i || illegal) ? 32'h0 : old_val;
  assign bus.csr_illegal_o = illegal;
  assign bus.redirect_o    = trap || take_mret;
  assign bus.redirect_pc_o = trap ? trap_target : (take_mret ? mepc_q : 32'h0);
  assign bus.irq_pending_o = !rst_i && irq_valid;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= TRAP_PC & MTVEC_MASK;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
    end else begin
      if (csr_we) begin
        case (bus.csr_addr_i)
          CSR_MSTATUS: begin
            mstatus_mie_q  <= new_val[3];
            mstatus_mpie_q <= new_val[7];
          end
          CSR_MIE:      mie_q      <= new_val & MIE_MASK;
          CSR_MTVEC:    mtvec_q    <= new_val & MTVEC_MASK;
          CSR_MSCRATCH: mscratch_q <= new_val;
          CSR_MEPC:     mepc_q     <= new_val & MEPC_MASK;
          CSR_MCAUSE:   mcause_q   <= new_val;
          CSR_MTVAL:    mtval_q    <= new_val;
          default: ;
        endcase
      end
      if (trap) begin
        mepc_q         <= bus.pc_i & MEPC_MASK;
        mcause_q       <= trap_cause;
        mtval_q        <= bus.exc_valid_i ? bus.exc_tval_i : 32'h0;
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end else if (take_mret) begin
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller
//   Directed-vector bench for trap_controller (TRAP_PC=0x100, 4 local lines,
//   vectored mode allowed). Expected values are hand-computed constants.
module tb_trap_controller;
  import trap_controller_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [31:0] rd;
  logic        ill;

  trap_controller_if #(.NUM_LOCAL_IRQ(4)) bus ();

  trap_controller #(
    .NUM_LOCAL_IRQ (4),
    .TRAP_PC       (32'h0000_0100),
    .VECTORED      (1'b1)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.csr_valid_i    = 1'b0;
    bus.csr_addr_i     = '0;
    bus.csr_op_i       = '0;
    bus.csr_wdata_i    = '0;
    bus.timer_irq_i    = 1'b0;
    bus.external_irq_i = 1'b0;
    bus.local_irq_i    = '0;
    bus.boundary_i     = 1'b0;
    bus.pc_i           = '0;
    bus.exc_valid_i    = 1'b0;
    bus.exc_cause_i    = '0;
    bus.exc_tval_i     = '0;
    bus.mret_i         = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_access(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                            output logic [31:0] r, output logic il);
    bus.csr_valid_i = 1'b1;
    bus.csr_addr_i  = a;
    bus.csr_op_i    = op;
    bus.csr_wdata_i = wd;
    #1;
    r  = bus.csr_rdata_o;
    il = bus.csr_illegal_o;
    tick();
    bus.csr_valid_i = 1'b0;
    bus.csr_wdata_i = '0;
  endtask

  task automatic chk_csr(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic        il;
    csr_access(a, CSR_OP_RS, 32'h0, r, il);
    chk(tag, r, exp);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    rst = 1'b1;
    // Reset: inputs that would otherwise trap / flag illegal are ignored.
    bus.csr_valid_i = 1'b1;
    bus.csr_addr_i  = 12'h7FF;
    bus.csr_op_i    = CSR_OP_RSV;
    bus.boundary_i  = 1'b1;
    bus.exc_valid_i = 1'b1;
    bus.timer_irq_i = 1'b1;
    tick();
    chk("rst_redirect", 32'(bus.redirect_o), 32'h0);
    chk("rst_illegal",  32'(bus.csr_illegal_o), 32'h0);
    chk("rst_rdata",    bus.csr_rdata_o, 32'h0);
    chk("rst_pending",  32'(bus.irq_pending_o), 32'h0);
    tick();
    rst = 1'b0;
    idle();

    chk_csr("mtvec_reset",   CSR_MTVEC,   32'h0000_0100);
    chk_csr("mstatus_reset", CSR_MSTATUS, 32'h0000_1800);
    chk_csr("mie_reset",     CSR_MIE,     32'h0);
    chk_csr("mip_reset",     CSR_MIP,     32'h0);

    // RS / RC / RW and illegal access
    csr_access(CSR_MIE, CSR_OP_RS, 32'h880, rd, ill);
    chk("rs_mie_old", rd, 32'h0);
    chk_csr("rs_mie", CSR_MIE, 32'h880);
    csr_access(CSR_MIE, CSR_OP_RC, 32'h80, rd, ill);
    chk("rc_mie_old", rd, 32'h880);
    chk_csr("rc_mie", CSR_MIE, 32'h800);
    csr_access(12'h7FF, CSR_OP_RW, 32'hFFFF, rd, ill);
    chk("bad_addr_ill", 32'(ill), 32'h1);
    chk("bad_addr_rd",  rd, 32'h0);
    csr_access(CSR_MIE, CSR_OP_RSV, 32'hFFFF, rd, ill);
    chk("rsv_op_ill", 32'(ill), 32'h1);
    chk("rsv_op_rd",  rd, 32'h0);
    chk_csr("mie_unchanged", CSR_MIE, 32'h800);
    csr_access(CSR_MEPC, CSR_OP_RW, 32'h1003, rd, ill);
    chk_csr("mepc_align", CSR_MEPC, 32'h1000);
    csr_access(CSR_MIE, CSR_OP_RW, 32'hFFFF_FFFF, rd, ill);
    chk_csr("mie_mask", CSR_MIE, 32'h000F_0880);
    csr_access(CSR_MIP, CSR_OP_RW, 32'hFFFF, rd, ill);
    chk("mip_wr_ill", 32'(ill), 32'h0);
    bus.timer_irq_i = 1'b1;
    bus.local_irq_i = 4'b0101;
    chk_csr("mip_mirror", CSR_MIP, 32'h0005_0080);
    bus.timer_irq_i = 1'b0;
    bus.local_irq_i = '0;
    csr_access(CSR_MTVEC, CSR_OP_RW, 32'hFFF, rd, ill);
    chk_csr("mtvec_mask", CSR_MTVEC, 32'h0000_0FFD);
    csr_access(CSR_MTVEC, CSR_OP_RW, 32'h100, rd, ill);

    // Timer interrupt, direct mode
    csr_access(CSR_MIE, CSR_OP_RW, 32'h80, rd, ill);
    csr_access(CSR_MSTATUS, CSR_OP_RS, 32'h8, rd, ill);
    chk_csr("mstatus_mie_set", CSR_MSTATUS, 32'h0000_1808);
    bus.timer_irq_i = 1'b1;
    #1;
    chk("mti_pending",     32'(bus.irq_pending_o), 32'h1);
    chk("mti_no_boundary", 32'(bus.redirect_o), 32'h0);
    bus.boundary_i = 1'b1;
    bus.pc_i       = 32'h2000;
    #1;
    chk("mti_redirect", 32'(bus.redirect_o), 32'h1);
    chk("mti_target",   bus.redirect_pc_o, 32'h100);
    tick();
    idle();
    chk_csr("mti_mepc",    CSR_MEPC,    32'h2000);
    chk_csr("mti_mcause",  CSR_MCAUSE,  32'h8000_0007);
    chk_csr("mti_mtval",   CSR_MTVAL,   32'h0);
    chk_csr("mti_mstatus", CSR_MSTATUS, 32'h0000_1880);
    bus.timer_irq_i = 1'b1;
    #1;
    chk("masked_pending", 32'(bus.irq_pending_o), 32'h0);
    bus.timer_irq_i = 1'b0;

    // mret
    bus.mret_i     = 1'b1;
    bus.boundary_i = 1'b1;
    #1;
    chk("mret_redirect", 32'(bus.redirect_o), 32'h1);
    chk("mret_target",   bus.redirect_pc_o, 32'h2000);
    tick();
    idle();
    chk_csr("mret_mstatus", CSR_MSTATUS, 32'h0000_1888);

    // mret and a CSR write lose to a pending interrupt
    bus.timer_irq_i = 1'b1;
    bus.mret_i      = 1'b1;
    bus.boundary_i  = 1'b1;
    bus.pc_i        = 32'h3000;
    bus.csr_valid_i = 1'b1;
    bus.csr_addr_i  = CSR_MSCRATCH;
    bus.csr_op_i    = CSR_OP_RW;
    bus.csr_wdata_i = 32'hAA;
    #1;
    chk("mret_irq_target", bus.redirect_pc_o, 32'h100);
    chk("mret_irq_ill",    32'(bus.csr_illegal_o), 32'h0);
    tick();
    idle();
    chk_csr("mret_dropped",   CSR_MSTATUS,  32'h0000_1880);
    chk_csr("mret_irq_mepc",  CSR_MEPC,     32'h3000);
    chk_csr("csr_wr_dropped", CSR_MSCRATCH, 32'h0);

    // Vectored mode and priority
    csr_access(CSR_MTVEC, CSR_OP_RW, 32'h401, rd, ill);
    chk_csr("mtvec_vec", CSR_MTVEC, 32'h401);
    csr_access(CSR_MIE, CSR_OP_RW, 32'h0001_0880, rd, ill);
    csr_access(CSR_MSTATUS, CSR_OP_RS, 32'h8, rd, ill);
    bus.external_irq_i = 1'b1;
    bus.timer_irq_i    = 1'b1;
    bus.local_irq_i    = 4'b0001;
    bus.boundary_i     = 1'b1;
    bus.pc_i           = 32'h4000;
    #1;
    chk("vec_mei_target", bus.redirect_pc_o, 32'h42C);
    bus.exc_valid_i = 1'b1;
    bus.exc_cause_i = 4'd2;
    bus.exc_tval_i  = 32'hDEAD_BEEF;
    bus.csr_valid_i = 1'b1;
    bus.csr_addr_i  = 12'h7FF;
    bus.csr_op_i    = CSR_OP_RSV;
    #1;
    chk("exc_target",     bus.redirect_pc_o, 32'h400);
    chk("exc_ill_forced", 32'(bus.csr_illegal_o), 32'h0);
    tick();
    idle();
    chk_csr("exc_mcause",  CSR_MCAUSE,  32'h2);
    chk_csr("exc_mtval",   CSR_MTVAL,   32'hDEAD_BEEF);
    chk_csr("exc_mepc",    CSR_MEPC,    32'h4000);
    chk_csr("exc_mstatus", CSR_MSTATUS, 32'h0000_1880);
    bus.mret_i     = 1'b1;
    bus.boundary_i = 1'b1;
    #1;
    chk("mret2_target", bus.redirect_pc_o, 32'h4000);
    tick();
    idle();
    bus.timer_irq_i = 1'b1;
    bus.local_irq_i = 4'b0001;
    bus.boundary_i  = 1'b1;
    bus.pc_i        = 32'h5000;
    #1;
    chk("vec_mti_target", bus.redirect_pc_o, 32'h41C);
    bus.timer_irq_i = 1'b0;
    bus.local_irq_i = 4'b0101;
    #1;
    chk("vec_local_target", bus.redirect_pc_o, 32'h440);
    tick();
    idle();
    chk_csr("local_mcause", CSR_MCAUSE, 32'h8000_0010);
    chk_csr("local_mtval",  CSR_MTVAL,  32'h0);

    // Reset in the same cycle as a trap
    csr_access(CSR_MSTATUS, CSR_OP_RS, 32'h8, rd, ill);
    bus.timer_irq_i = 1'b1;
    bus.boundary_i  = 1'b1;
    bus.pc_i        = 32'h6000;
    rst             = 1'b1;
    #1;
    chk("rst_trap_redirect", 32'(bus.redirect_o), 32'h0);
    tick();
    rst = 1'b0;
    idle();
    chk_csr("post_rst_mtvec",    CSR_MTVEC,    32'h100);
    chk_csr("post_rst_mstatus",  CSR_MSTATUS,  32'h0000_1800);
    chk_csr("post_rst_mie",      CSR_MIE,      32'h0);
    chk_csr("post_rst_mepc",     CSR_MEPC,     32'h0);
    chk_csr("post_rst_mcause",   CSR_MCAUSE,   32'h0);
    chk_csr("post_rst_mtval",    CSR_MTVAL,    32'h0);
    chk_csr("post_rst_mscratch", CSR_MSCRATCH, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
